// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, FSM state codes and address-field helpers
// for the direct-mapped write-back cache controller.
package cache_pkg;
    localparam int LINE_W = 128;
    localparam int WORDS_PER_LINE = 4;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE      = 2'd0;
    localparam state_t S_COMPARE   = 2'd1;
    localparam state_t S_WRITEBACK = 2'd2;
    localparam state_t S_ALLOCATE  = 2'd3;

    function automatic int tag_w(input int addr_w, input int num_lines);
        return addr_w - 4 - $clog2(num_lines);
    endfunction

    function automatic logic [1:0] word_of(input logic [31:0] a);
        return 2'(a >> 2);
    endfunction

    // Callers truncate to their index width.
    function automatic logic [31:0] index_of(input logic [31:0] a);
        return a >> 4;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a, input int idx_w);
        return a >> (4 + idx_w);
    endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: tag/valid/dirty/data arrays of the direct-mapped cache
// with word-write, line-fill and dirty-clear ports on a single index.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int TAG_W = 4,
    parameter int IDX_W = $clog2(NUM_LINES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IDX_W-1:0]          index,
    input  logic                      wr_en,
    input  logic [1:0]                wr_word,
    input  logic [31:0]               wr_data,
    input  logic                      fill_en,
    input  logic [TAG_W-1:0]          fill_tag,
    input  logic [LINE_W-1:0]         fill_data,
    input  logic                      clr_dirty,
    output logic                      valid,
    output logic [TAG_W-1:0]          tag,
    output logic [LINE_W-1:0]         data,
    output logic [WORDS_PER_LINE-1:0] dirty
);
    logic [NUM_LINES-1:0]      valid_q;
    logic [WORDS_PER_LINE-1:0] dirty_q [NUM_LINES];
    logic [TAG_W-1:0]          tag_q   [NUM_LINES];
    logic [LINE_W-1:0]         data_q  [NUM_LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_LINES; i++) dirty_q[i] <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= '0;
        end else if (clr_dirty) begin
            dirty_q[index] <= '0;
        end else if (wr_en) begin
            dirty_q[index][wr_word] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only valid/dirty are cleared.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (wr_en) begin
            data_q[index][{wr_word, 5'b0} +: 32] <= wr_data;
        end
    end

    assign valid = valid_q[index];
    assign tag   = tag_q[index];
    assign data  = data_q[index];
    assign dirty = dirty_q[index];
endmodule

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: hit / writeback / allocate sequencer for a direct-mapped
// write-back cache with 4-word lines, plus saturating hit/miss counters.
module cache_ctrl_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NUM_LINES = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuReq,
    input  logic              isRead,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              isHit,
    output logic              cpuDone,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddress,
    output logic [127:0]      memWriteData,
    output logic [3:0]        isDirty,
    input  logic [127:0]      memReadData,
    input  logic              memAck,
    output logic [CNT_W-1:0]  hitCount,
    output logic [CNT_W-1:0]  missCount
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = tag_w(ADDR_W, NUM_LINES);

    state_t              state;
    logic                req_read;
    logic [ADDR_W-1:2]   req_addr;
    logic [31:0]         req_wdata;
    logic                miss_flag;
    logic [31:0]         full_addr;
    logic [1:0]          req_word;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                line_valid;
    logic [TAG_W-1:0]    line_tag;
    logic [LINE_W-1:0]   line_data;
    logic [3:0]          line_dirty;
    logic                hit;
    logic                victim_dirty;
    logic                wr_en;
    logic                fill_en;
    logic                clr_dirty;

    assign full_addr    = 32'({req_addr, 2'b00});
    assign req_word     = word_of(full_addr);
    assign req_idx      = IDX_W'(index_of(full_addr));
    assign req_tag      = TAG_W'(tag_of(full_addr, IDX_W));
    assign hit          = line_valid && line_tag == req_tag;
    assign victim_dirty = line_valid && |line_dirty;
    assign wr_en        = state == S_COMPARE && hit && !req_read;
    assign fill_en      = state == S_ALLOCATE && memReq && memAck;
    assign clr_dirty    = state == S_WRITEBACK && memReq && memAck;

    cache_line_store #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_store (
        .clk      (clk),
        .rst      (reset),
        .index    (req_idx),
        .wr_en    (wr_en),
        .wr_word  (req_word),
        .wr_data  (req_wdata),
        .fill_en  (fill_en),
        .fill_tag (req_tag),
        .fill_data(memReadData),
        .clr_dirty(clr_dirty),
        .valid    (line_valid),
        .tag      (line_tag),
        .data     (line_data),
        .dirty    (line_dirty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            req_read     <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            miss_flag    <= 1'b0;
            cpuDone      <= 1'b0;
            isHit        <= 1'b0;
            readData     <= '0;
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            isDirty      <= '0;
            hitCount     <= '0;
            missCount    <= '0;
        end else begin
            cpuDone <= 1'b0;
            case (state)
                S_IDLE: if (cpuReq && !cpuDone) begin
                    req_read  <= isRead;
                    req_addr  <= address[ADDR_W-1:2];
                    req_wdata <= writeData;
                    miss_flag <= 1'b0;
                    state     <= S_COMPARE;
                end
                S_COMPARE: if (hit) begin
                    if (req_read) readData <= line_data[{req_word, 5'b0} +: 32];
                    cpuDone <= 1'b1;
                    isHit   <= !miss_flag;
                    if (!miss_flag && !(&hitCount)) hitCount <= hitCount + 1'b1;
                    state   <= S_IDLE;
                end else begin
                    miss_flag <= 1'b1;
                    if (!(&missCount)) missCount <= missCount + 1'b1;
                    memReq       <= 1'b1;
                    memWe        <= victim_dirty;
                    memAddress   <= victim_dirty ? {line_tag, req_idx, 4'b0} : {req_tag, req_idx, 4'b0};
                    memWriteData <= line_data;
                    isDirty      <= victim_dirty ? line_dirty : 4'b0;
                    state        <= victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                end
                S_WRITEBACK: if (memAck) begin
                    memReq <= 1'b0;
                    memWe  <= 1'b0;
                    state  <= S_ALLOCATE;
                end
                // After a writeback memReq spends one cycle low before the fill request.
                S_ALLOCATE: if (!memReq) begin
                    memReq     <= 1'b1;
                    memWe      <= 1'b0;
                    memAddress <= {req_tag, req_idx, 4'b0};
                end else if (memAck) begin
                    memReq <= 1'b0;
                    state  <= S_COMPARE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
